// File: rtl/oam_dma_ctrl_if.sv
// CPU-bus / OAM bundle between the top-level bus mux and the sprite-DMA sequencer.
// The sequencer connects through the slave modport; the bus side uses master.
interface oam_dma_ctrl_if;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_data_out;
   logic        cpu_rw_n;
   logic [7:0]  bus_data_in;
   logic        cpu_halt;
   logic        dma_bus_own;
   logic [15:0] dma_addr;
   logic        dma_rden;
   logic        oam_wren;
   logic [7:0]  oam_addr;
   logic [7:0]  oam_data;
   logic        dma_done;

   modport slave (
      input  cpu_addr, cpu_data_out, cpu_rw_n, bus_data_in,
      output cpu_halt, dma_bus_own, dma_addr, dma_rden,
      output oam_wren, oam_addr, oam_data, dma_done
   );

   modport master (
      output cpu_addr, cpu_data_out, cpu_rw_n, bus_data_in,
      input  cpu_halt, dma_bus_own, dma_addr, dma_rden,
      input  oam_wren, oam_addr, oam_data, dma_done
   );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite-DMA sequencer: a CPU write to DMA_REG_ADDR halts the CPU and copies one page into OAM.
// Optional macro OAM_DMA_ALIGN_EN adds get/put parity tracking and the ALIGN state.
module oam_dma_ctrl #(
   parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
   parameter int unsigned XFER_LEN     = 256
) (
   input logic           CLK,
   input logic           RESET,
   input logic           ENABLE,
   oam_dma_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HALT  = 3'd1,
      S_ALIGN = 3'd2,
      S_GET   = 3'd3,
      S_PUT   = 3'd4
   } state_e;

   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   state_e     state_q, state_d;
   logic [7:0] page_q, page_d;
   logic [7:0] idx_q, idx_d;
   logic       done_q, done_d;
   logic       trigger;

   assign trigger = (state_q == S_IDLE) && !bus.cpu_rw_n && (bus.cpu_addr == DMA_REG_ADDR);

`ifdef OAM_DMA_ALIGN_EN
   logic par_q, par_d;

   // GET always lands on par==0, so the flop toggles on every enabled cycle
   always_ff @(posedge CLK) begin
      if (RESET) begin
         par_q <= 1'b0;
      end else begin
         par_q <= par_d;
      end
   end

   always_comb begin
      if (ENABLE) begin
         par_d = ~par_q;
      end else begin
         par_d = par_q;
      end
   end
`endif

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         page_q  <= 8'd0;
         idx_q   <= 8'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         page_q  <= page_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      idx_d   = idx_q;
      done_d  = done_q;
      if (ENABLE) begin
         done_d = 1'b0;
         case (state_q)
            S_IDLE: begin
               if (trigger) begin
                  page_d  = bus.cpu_data_out;
                  idx_d   = 8'd0;
                  state_d = S_HALT;
               end else begin
                  state_d = S_IDLE;
               end
            end
`ifdef OAM_DMA_ALIGN_EN
            S_HALT: begin
               if (par_q) begin
                  state_d = S_GET;
               end else begin
                  state_d = S_ALIGN;
               end
            end
            S_ALIGN: state_d = S_GET;
`else
            S_HALT:  state_d = S_GET;
`endif
            S_GET:   state_d = S_PUT;
            S_PUT: begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = 8'd0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_q + 8'd1;
                  state_d = S_GET;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Outputs decode from registered state; only oam_data passes the bus through
   always_comb begin
      bus.cpu_halt    = 1'b0;
      bus.dma_bus_own = 1'b0;
      bus.dma_addr    = 16'h0000;
      bus.dma_rden    = 1'b0;
      bus.oam_wren    = 1'b0;
      bus.oam_addr    = 8'h00;
      bus.oam_data    = 8'h00;
      bus.dma_done    = done_q;
      case (state_q)
         S_IDLE:  bus.cpu_halt = 1'b0;
         S_HALT:  bus.cpu_halt = 1'b1;
         S_ALIGN: bus.cpu_halt = 1'b1;
         S_GET: begin
            bus.cpu_halt    = 1'b1;
            bus.dma_bus_own = 1'b1;
            bus.dma_addr    = {page_q, idx_q};
            bus.dma_rden    = 1'b1;
            bus.oam_addr    = idx_q;
         end
         S_PUT: begin
            bus.cpu_halt    = 1'b1;
            bus.dma_bus_own = 1'b1;
            bus.dma_addr    = {page_q, idx_q};
            bus.oam_wren    = 1'b1;
            bus.oam_addr    = idx_q;
            bus.oam_data    = bus.bus_data_in;
         end
         default: bus.cpu_halt = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: trigger decode table plus full-transfer, stall, reset and back-to-back sequences.
module tb_oam_dma_ctrl;
   localparam logic [15:0] DMA_REG = 16'h4014;

   logic CLK;
   logic RESET;
   logic ENABLE;

   oam_dma_ctrl_if intf ();

   oam_dma_ctrl #(.DMA_REG_ADDR(DMA_REG), .XFER_LEN(256)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .ENABLE(ENABLE),
      .bus   (intf)
   );

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      logic        rw_n;
      logic        en;
      logic        exp_halt;
   } vec_t;

   vec_t       vecs [6];
   int         tests = 0;
   int         fails = 0;
   bit         tb_par;
   bit         trig_par;
   bit         clr_req;
   logic [7:0] mem_q;
   logic [7:0] oam [256];

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // parity reference, synchronous memory returning addr^5A, and OAM model
   always @(posedge CLK) begin
      if (RESET) tb_par <= 1'b0;
      else if (ENABLE) tb_par <= ~tb_par;
      if (ENABLE) mem_q <= intf.dma_addr[7:0] ^ 8'h5A;
      if (clr_req) begin
         for (int k = 0; k < 256; k++) oam[k] <= 8'hEE;
      end else if (ENABLE && intf.oam_wren) begin
         oam[intf.oam_addr] <= intf.oam_data;
      end
   end

   assign intf.bus_data_in = mem_q;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_bus();
      intf.cpu_addr     = 16'h0000;
      intf.cpu_data_out = 8'h00;
      intf.cpu_rw_n     = 1'b1;
   endtask

   task automatic drive_write(input logic [15:0] a, input logic [7:0] d);
      intf.cpu_addr     = a;
      intf.cpu_data_out = d;
      intf.cpu_rw_n     = 1'b0;
   endtask

   task automatic drive_trigger(input logic [7:0] pg);
      drive_write(DMA_REG, pg);
      trig_par = tb_par;
   endtask

   task automatic wait_par(input bit p);
      for (int i = 0; i < 4; i++) begin
         if (tb_par == p) break;
         tick();
      end
   endtask

   task automatic clear_oam();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
   endtask

   task automatic check_oam();
      int errs;
      logic [7:0] iv;
      errs = 0;
      for (int i = 0; i < 256; i++) begin
         iv = 8'(i);
         if (oam[i] !== (iv ^ 8'h5A)) errs++;
      end
      check("oam_contents", errs, 0);
   endtask

   // Trigger already driven in the current cycle; follows the transfer until cpu_halt falls.
   task automatic run_body(input logic [7:0] pg, input bit stall, input bit inject);
      int halt_cnt, n_get, first_get, bad, guard, align_exp;
      bit stalled;
      logic [7:0] exp_idx;
      halt_cnt = 0; n_get = 0; first_get = -1; bad = 0; guard = 0; stalled = 1'b0;
`ifdef OAM_DMA_ALIGN_EN
      align_exp = trig_par ? 1 : 0;
`else
      align_exp = 0;
`endif
      tick();
      idle_bus();
      check("halt_rise", intf.cpu_halt, 1);
      while (intf.cpu_halt === 1'b1 && guard < 2000) begin
         if (stall && !stalled && intf.dma_rden === 1'b1 && n_get == 50) begin
            ENABLE = 1'b0;
            for (int i = 0; i < 10; i++) begin
               tick();
               if (intf.dma_rden !== 1'b1 || intf.dma_addr !== {pg, 8'd50}) bad++;
            end
            ENABLE  = 1'b1;
            stalled = 1'b1;
         end
         halt_cnt++;
         if (intf.dma_done !== 1'b0) bad++;
         if (intf.dma_rden === 1'b1) begin
            if (first_get < 0) first_get = halt_cnt - 1;
            if (intf.dma_addr !== {pg, n_get[7:0]} || intf.oam_wren !== 1'b0 ||
                intf.dma_bus_own !== 1'b1) bad++;
            n_get++;
         end else if (intf.oam_wren === 1'b1) begin
            exp_idx = 8'(n_get - 1);
            if (intf.dma_bus_own !== 1'b1 || intf.oam_addr !== exp_idx ||
                intf.oam_data !== (exp_idx ^ 8'h5A)) bad++;
         end else if (intf.dma_bus_own !== 1'b0 || intf.dma_addr !== 16'h0000) begin
            bad++;
         end
         if (inject && intf.dma_rden === 1'b1 && n_get == 30) drive_write(DMA_REG, 8'h77);
         else if (inject && intf.dma_rden === 1'b1 && n_get == 60) drive_write(16'h4015, 8'h99);
         else idle_bus();
         tick();
         guard++;
      end
      check("halt_timeout", (guard < 2000) ? 1 : 0, 1);
      check("done_pulse", intf.dma_done, 1);
      check("halt_len", halt_cnt, 513 + align_exp);
      check("first_get", first_get, 1 + align_exp);
      check("get_count", n_get, 256);
      check("bus_seq_errs", bad, 0);
   endtask

   initial begin
      int n, guard, bad;
      clr_req = 1'b0;
      ENABLE  = 1'b1;
      RESET   = 1'b1;
      idle_bus();

      vecs[0] = '{16'h4014, 8'h11, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{16'h4015, 8'h22, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{16'h4014, 8'h33, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{16'h0014, 8'h44, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{16'hC014, 8'h55, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{16'h4014, 8'h66, 1'b0, 1'b1, 1'b1};

      tick();
      tick();
      check("rst_halt", intf.cpu_halt, 0);
      check("rst_own", intf.dma_bus_own, 0);
      check("rst_dma_addr", intf.dma_addr, 0);
      check("rst_strobes", {intf.dma_rden, intf.oam_wren, intf.dma_done}, 0);
      check("rst_oam_bus", {intf.oam_addr, intf.oam_data}, 0);
      RESET = 1'b0;

      // trigger decode: one cycle of each pattern, then a reset back to IDLE
      for (int i = 0; i < 6; i++) begin
         intf.cpu_addr     = vecs[i].addr;
         intf.cpu_data_out = vecs[i].data;
         intf.cpu_rw_n     = vecs[i].rw_n;
         ENABLE            = vecs[i].en;
         tick();
         idle_bus();
         ENABLE = 1'b1;
         check($sformatf("vec%0d_halt", i), intf.cpu_halt, vecs[i].exp_halt);
         check($sformatf("vec%0d_own", i), intf.dma_bus_own, 0);
         RESET = 1'b1;
         tick();
         RESET = 1'b0;
      end

      // transfer with HALT seeing par==1: no align cycle
      clear_oam();
      wait_par(1'b0);
      drive_trigger(8'h02);
      run_body(8'h02, 1'b0, 1'b0);
      tick();
      check("done_clear", intf.dma_done, 0);
      check("idle_after", intf.cpu_halt, 0);
      check_oam();

      // opposite parity, 10-cycle stall, ignored writes, then back-to-back trigger
      clear_oam();
      wait_par(1'b1);
      drive_trigger(8'h02);
      run_body(8'h02, 1'b1, 1'b1);
      check_oam();
      drive_trigger(8'h05);
      run_body(8'h05, 1'b0, 1'b0);
      tick();
      check("b2b_done_clear", intf.dma_done, 0);

      // reset at the 100th GET
      clear_oam();
      wait_par(1'b0);
      drive_trigger(8'h21);
      tick();
      idle_bus();
      n = 0;
      guard = 0;
      while (guard < 1000) begin
         if (intf.dma_rden === 1'b1) begin
            n++;
            if (n == 100) break;
         end
         tick();
         guard++;
      end
      check("rst_reach_get100", n, 100);
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      check("midrst_halt", intf.cpu_halt, 0);
      check("midrst_own", intf.dma_bus_own, 0);
      check("midrst_wren", intf.oam_wren, 0);
      check("midrst_done", intf.dma_done, 0);
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (intf.dma_done !== 1'b0 || intf.cpu_halt !== 1'b0) bad++;
      end
      check("midrst_quiet", bad, 0);
      check("midrst_oam98", oam[98], 8'd98 ^ 8'h5A);
      check("midrst_oam99", oam[99], 8'hEE);
      wait_par(1'b0);
      drive_trigger(8'h13);
      run_body(8'h13, 1'b0, 1'b0);
      tick();
      check("restart_idle", intf.cpu_halt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
